// File: rtl/ahb_lite_soc_pkg.sv
// Shared AHB-Lite encodings, address map, command ROM format and the default program.
// Optional build macro used by the SRAM slave: SRAM_WAIT_STATE_EN.
package ahb_lite_soc_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_HALT  = 2'd3
  } op_e;

  // Upper address nibble (HADDR[31:28]) of each slave region.
  localparam logic [3:0] MAP_SRAM = 4'h0;
  localparam logic [3:0] MAP_GPIO = 4'h4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SRAM = 2'd1,
    SEL_GPIO = 2'd2,
    SEL_DEF  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CANCEL = 2'd1,
    ST_HALTED = 2'd2
  } mstate_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic sel_e decode(input logic [3:0] region);
    case (region)
      MAP_SRAM: decode = SEL_SRAM;
      MAP_GPIO: decode = SEL_GPIO;
      default:  decode = SEL_DEF;
    endcase
  endfunction

  // Packed array: rightmost entry is command 0.
  localparam cmd_t [7:0] DEFAULT_PROG = {
    cmd_t'{op: OP_HALT,  addr: 32'h0000_0000, wdata: 32'h0000_0000},
    cmd_t'{op: OP_READ,  addr: 32'h8000_0000, wdata: 32'h0000_0000},
    cmd_t'{op: OP_READ,  addr: 32'h4000_0000, wdata: 32'h0000_0000},
    cmd_t'{op: OP_WRITE, addr: 32'h4000_0000, wdata: 32'h0000_00A5},
    cmd_t'{op: OP_READ,  addr: 32'h0000_0004, wdata: 32'h0000_0000},
    cmd_t'{op: OP_READ,  addr: 32'h0000_0000, wdata: 32'h0000_0000},
    cmd_t'{op: OP_WRITE, addr: 32'h0000_0004, wdata: 32'h1234_5678},
    cmd_t'{op: OP_WRITE, addr: 32'h0000_0000, wdata: 32'hDEAD_BEEF}
  };

endpackage

// File: rtl/ahb_lite_soc_sram.sv
// Word SRAM slave with its own registered data phase.
// Defining SRAM_WAIT_STATE_EN inserts one wait state on every accepted transfer.
module ahb_lite_soc_sram #(
  parameter int SRAM_WORDS = 256,
  parameter int IDX_W      = $clog2(SRAM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             write,
  input  logic             hready_in,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             hready_out
);

  logic [31:0]      mem [SRAM_WORDS];
  logic             dp_active_q, dp_active_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
  logic             commit;

  always_comb begin
    dp_active_d = dp_active_q;
    dp_write_d  = dp_write_q;
    dp_idx_d    = dp_idx_q;
    if (hready_in) begin
      dp_active_d = sel;
      dp_write_d  = write;
      dp_idx_d    = idx;
    end
  end

`ifdef SRAM_WAIT_STATE_EN
  logic waited_q, waited_d;

  always_comb begin
    waited_d   = dp_active_q && !waited_q;
    hready_out = !dp_active_q || waited_q;
  end

  always_ff @(posedge clk) begin
    if (rst) waited_q <= 1'b0;
    else     waited_q <= waited_d;
  end
`else
  assign hready_out = 1'b1;
`endif

  // Writes land at the end of their data phase, so a read in the very next
  // data phase already sees the new word through the combinational read port.
  assign rdata  = mem[dp_idx_q];
  assign commit = dp_active_q && dp_write_q && hready_out && !rst;

  always_ff @(posedge clk) begin
    if (commit) mem[dp_idx_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_active_q <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
    end else begin
      dp_active_q <= dp_active_d;
      dp_write_q  <= dp_write_d;
      dp_idx_q    <= dp_idx_d;
    end
  end

endmodule

// File: rtl/ahb_lite_soc.sv
// AHB-Lite subsystem: ROM-driven master, decoder, SRAM/GPIO/default slaves and response mux.
// Build option SRAM_WAIT_STATE_EN adds one SRAM wait state per transfer.
module ahb_lite_soc
  import ahb_lite_soc_pkg::*;
#(
  parameter int                     SRAM_WORDS = 256,
  parameter int                     PROG_DEPTH = 8,
  parameter cmd_t [PROG_DEPTH-1:0]  PROG       = DEFAULT_PROG
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] gpio_out,
  output logic [31:0] checksum,
  output logic [31:0] last_rdata,
  output logic        bus_error,
  output logic        halted
);

  localparam int PC_W  = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int IDX_W = $clog2(SRAM_WORDS);

  // Handshake: an address phase is accepted on a cycle with HTRANS=NONSEQ and
  // HREADY=1; its data phase then runs until the next cycle with HREADY=1.
  mstate_e          state_q, state_d, dbg_master_state;
  logic [PC_W-1:0]  pc_q, pc_d;
  cmd_t             cmd;
  htrans_e          htrans;
  logic [31:0]      haddr, hwdata, hrdata;
  logic             hwrite, hready, hresp;
  sel_e             a_sel;

  logic             dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  sel_e             dp_sel_q, dp_sel_d;
  logic [31:0]      dp_wdata_q, dp_wdata_d;
  logic             err2_q, err2_d, def_active, def_hready;
  logic [31:0]      gpio_q, gpio_d, checksum_q, checksum_d, last_q, last_d;
  logic             bus_error_q, bus_error_d;
  logic [31:0]      sram_rdata;
  logic             sram_hready;
  logic             unused_addr_bits;

  assign cmd              = PROG[pc_q];
  assign haddr            = cmd.addr;
  assign hwrite           = (cmd.op == OP_WRITE);
  assign hwdata           = dp_wdata_q;
  assign a_sel            = decode(haddr[31:28]);
  assign dbg_master_state = state_q;
  assign unused_addr_bits = ^{haddr[27:IDX_W+2], haddr[1:0]};

  // Master FSM: ST_CANCEL is the IDLE cycle forced during an ERROR's second cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dp_valid_q && !hready && hresp)                  state_d = ST_CANCEL;
        else if (hready && cmd.op == OP_HALT && !dp_valid_q) state_d = ST_HALTED;
      end
      ST_CANCEL: if (hready) state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    htrans = HTRANS_IDLE;
    pc_d   = pc_q;
    if (!HRESET && state_q == ST_RUN) begin
      if (cmd.op == OP_WRITE || cmd.op == OP_READ) htrans = HTRANS_NONSEQ;
      if (hready && cmd.op != OP_HALT)             pc_d   = pc_q + PC_W'(1);
    end
  end

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_sel_d   = dp_sel_q;
    dp_wdata_d = dp_wdata_q;
    if (hready) begin
      dp_valid_d = (htrans == HTRANS_NONSEQ);
      dp_write_d = hwrite;
      dp_sel_d   = a_sel;
      dp_wdata_d = cmd.wdata;
    end
  end

  ahb_lite_soc_sram #(.SRAM_WORDS(SRAM_WORDS), .IDX_W(IDX_W)) u_sram (
    .clk        (HCLK),
    .rst        (HRESET),
    .sel        (htrans == HTRANS_NONSEQ && a_sel == SEL_SRAM),
    .write      (hwrite),
    .hready_in  (hready),
    .idx        (haddr[IDX_W+1:2]),
    .wdata      (hwdata),
    .rdata      (sram_rdata),
    .hready_out (sram_hready)
  );

  // Default slave: two-cycle ERROR, first cycle stalls, second completes.
  assign def_active = dp_valid_q && dp_sel_q == SEL_DEF;
  assign def_hready = !def_active || err2_q;
  assign err2_d     = def_active && !err2_q;

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = '0;
    if (dp_valid_q) begin
      case (dp_sel_q)
        SEL_SRAM: begin
          hready = sram_hready;
          hrdata = sram_rdata;
        end
        SEL_GPIO: hrdata = gpio_q;
        SEL_DEF: begin
          hready = def_hready;
          hresp  = HRESP_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gpio_d      = gpio_q;
    checksum_d  = checksum_q;
    last_d      = last_q;
    bus_error_d = bus_error_q;
    if (dp_valid_q && hresp == HRESP_ERROR) bus_error_d = 1'b1;
    if (dp_valid_q && hready && hresp == HRESP_OKAY) begin
      if (dp_write_q) begin
        if (dp_sel_q == SEL_GPIO) gpio_d = hwdata;
      end else begin
        checksum_d = checksum_q ^ hrdata;
        last_d     = hrdata;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_sel_q    <= SEL_NONE;
      dp_wdata_q  <= '0;
      err2_q      <= 1'b0;
      gpio_q      <= '0;
      checksum_q  <= '0;
      last_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_sel_q    <= dp_sel_d;
      dp_wdata_q  <= dp_wdata_d;
      err2_q      <= err2_d;
      gpio_q      <= gpio_d;
      checksum_q  <= checksum_d;
      last_q      <= last_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign gpio_out   = gpio_q;
  assign checksum   = checksum_q;
  assign last_rdata = last_q;
  assign bus_error  = bus_error_q;
  assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ahb_lite_soc.sv
// Directed bench: default program, error response shape, index wrap and mid-run reset.
module tb_ahb_lite_soc;
  import ahb_lite_soc_pkg::*;

`ifdef SRAM_WAIT_STATE_EN
  localparam int          HALT_BUDGET = 16;
  localparam int          EXP_WAITS   = 4;
  localparam logic [31:0] MID_CS      = 32'h0000_0000;
`else
  localparam int          HALT_BUDGET = 12;
  localparam int          EXP_WAITS   = 0;
  localparam logic [31:0] MID_CS      = 32'hDEAD_BEEF;
`endif

  localparam cmd_t [7:0] WRAP_PROG = {
    {6{cmd_t'{op: OP_HALT, addr: 32'h0, wdata: 32'h0}}},
    cmd_t'{op: OP_READ,  addr: 32'h0000_0000, wdata: 32'h0},
    cmd_t'{op: OP_WRITE, addr: 32'h0000_0400, wdata: 32'h5A5A_0F0F}
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] gpio_out, checksum, last_rdata;
  logic        bus_error, halted;
  logic [31:0] w_gpio_out, w_checksum, w_last_rdata;
  logic        w_bus_error, w_halted;

  ahb_lite_soc dut (
    .HCLK(clk), .HRESET(rst), .gpio_out(gpio_out), .checksum(checksum),
    .last_rdata(last_rdata), .bus_error(bus_error), .halted(halted)
  );

  ahb_lite_soc #(.PROG(WRAP_PROG)) dut_w (
    .HCLK(clk), .HRESET(rst), .gpio_out(w_gpio_out), .checksum(w_checksum),
    .last_rdata(w_last_rdata), .bus_error(w_bus_error), .halted(w_halted)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    check32(tag, obs);
  endtask

  task automatic check_outputs_zero(input string tag);
    expect_check({tag, "_gpio"},      gpio_out,   32'h0);
    expect_check({tag, "_checksum"},  checksum,   32'h0);
    expect_check({tag, "_last"},      last_rdata, 32'h0);
    expect_check({tag, "_bus_error"}, {31'h0, bus_error}, 32'h0);
    expect_check({tag, "_halted"},    {31'h0, halted},    32'h0);
    expect_check({tag, "_htrans"},    32'(dut.htrans),    32'(HTRANS_IDLE));
  endtask

  task automatic check_finals(input string tag);
    expect_check({tag, "_halted"},    {31'h0, halted},    32'h1);
    expect_check({tag, "_checksum"},  checksum,           32'hCC99_E832);
    expect_check({tag, "_last"},      last_rdata,         32'h0000_00A5);
    expect_check({tag, "_gpio"},      gpio_out,           32'h0000_00A5);
    expect_check({tag, "_bus_error"}, {31'h0, bus_error}, 32'h1);
    expect_check({tag, "_w_halted"},  {31'h0, w_halted},  32'h1);
    expect_check({tag, "_w_last"},    w_last_rdata,       32'h5A5A_0F0F);
    expect_check({tag, "_w_checksum"}, w_checksum,        32'h5A5A_0F0F);
    expect_check({tag, "_w_bus_error"}, {31'h0, w_bus_error}, 32'h0);
    expect_check({tag, "_w_gpio"},    w_gpio_out,         32'h0);
  endtask

  // driver: runs from reset release until halted, watching the ERROR response
  task automatic run_prog(input string tag);
    int halt_at = -1;
    int err_at  = -1;
    int waits   = 0;
    logic [31:0] cs_before = '0;
    for (int c = 1; c <= 60 && halt_at < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (dut.dp_valid_q && dut.dp_sel_q == SEL_SRAM && !dut.hready) waits++;
      if (err_at < 0 && dut.hresp) begin
        err_at    = c;
        cs_before = checksum;
        expect_check({tag, "_err1_hready"}, {31'h0, dut.hready}, 32'h0);
      end else if (err_at > 0 && c == err_at + 1) begin
        expect_check({tag, "_err2_hready"}, {31'h0, dut.hready}, 32'h1);
        expect_check({tag, "_err2_hresp"},  {31'h0, dut.hresp},  32'h1);
      end else if (err_at > 0 && c == err_at + 2) begin
        expect_check({tag, "_post_err_hresp"}, {31'h0, dut.hresp}, 32'h0);
        expect_check({tag, "_err_cs_unchanged"}, checksum, cs_before);
        expect_check({tag, "_err_cs_value"}, checksum, 32'hCC99_E832);
      end
      if (halted) halt_at = c;
    end
    expect_check({tag, "_error_seen"}, {31'h0, err_at > 0}, 32'h1);
    expect_check({tag, "_halt_in_budget"}, {31'h0, halt_at > 0 && halt_at <= HALT_BUDGET}, 32'h1);
    expect_check({tag, "_sram_waits"}, 32'(waits), 32'(EXP_WAITS));
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");

    rst = 1'b0;
    #1;
    expect_check("first_htrans", 32'(dut.htrans), 32'(HTRANS_NONSEQ));
    expect_check("first_haddr",  dut.haddr,       32'h0000_0000);
    expect_check("first_hwrite", {31'h0, dut.hwrite}, 32'h1);

    run_prog("run1");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_finals("run1");

    // reset pulse part-way through the program
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_check("mid_checksum", checksum, MID_CS);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("pulse");
    rst = 1'b0;
    run_prog("run2");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_finals("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
